ps2_tx: RTL and testbench
=========================

Name: ps2_tx

Overview:
- Host-to-device PS/2 transmitter; the companion to the PS/2 receiver.
- Accepts one byte from the host logic and runs the host request-to-send sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop.
- Completes on the device acknowledge clock.
- Shares the ps2c/ps2d lines with the receiver; tx_idle gates the receiver's rx_en.

Parameters:
- RTS_CNT, 8191, clk cycles minus one that ps2c is held low for inhibit. Must give at least 100 us; 8191 gives 164 us at 50 MHz.
- FILT_LEN, 8, ps2c de-glitch filter length in samples.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_ps2  input  1  one-cycle start strobe; samples din.
- din  input  8  byte to transmit.
- ps2c  inout  1  PS/2 clock, open-drain: only driven 0 or released (Z); external pull-up.
- ps2d  inout  1  PS/2 data, open-drain: only driven 0 or released (Z).
- tx_idle  output  1  high while in idle; connect to receiver rx_en.
- tx_done_tick  output  1  one-cycle pulse when the transaction completes.

Behaviour:
- Reset (sync, active-high):
  - state=idle, filter=0, filtered clock=0, counters=0, shift reg=0.
  - Both lines released in the cycle after the reset edge.
  - tx_idle=1, tx_done_tick=0.
- ps2c filter:
  - FILT_LEN-bit shift register samples ps2c each clk.
  - Filtered clock goes to 1 when all samples are 1, to 0 when all are 0, else holds.
  - fall_edge = filtered_reg & ~filtered_next.
  - Pulses shorter than FILT_LEN cycles must not generate edges.
- Parity: odd; par = ~^din. Shift register b (9 bits) = {par, din}, loaded on accept.
- States (Moore outputs from state_reg):
  - idle:
    - Both lines released; tx_idle=1.
    - wr_ps2=1 loads b and c=RTS_CNT, then goes to rts. wr_ps2 in any other state is ignored; no queueing.
  - rts:
    - ps2c driven 0; ps2d released.
    - c decrements each cycle; at c==0 go to start.
    - Dwell is exactly RTS_CNT+1 cycles.
  - start:
    - ps2d driven 0 (start bit), ps2c released.
    - On fall_edge: n=8, go to data.
  - data:
    - ps2d = b[0] (0 drives low, 1 releases); ps2c released.
    - On fall_edge: b shifts right. If n==0 go to stop, else n=n-1.
    - 9 bits total: 8 data + parity.
  - stop:
    - Both lines released (stop bit = pull-up 1).
    - On fall_edge (the device acknowledge clock): tx_done_tick=1 for that cycle, go to idle.
  - Undefined state encoding goes to idle.
- Timing and edge rules:
  - Data changes in the cycle after a filtered falling edge, giving the device a full clock-high phase before its rising-edge sample.
  - fall_edge is ignored in idle and rts.
  - Ack polarity is not checked.
  - No timeout: a dead device leaves the FSM waiting in start, data or stop until reset.
- Reset mid-transaction:
  - Abort immediately; lines are released on the reset edge.
  - No tx_done_tick.
  - Next wr_ps2 after reset deassertion is accepted normally.
- wr_ps2 in the same cycle tx_done_tick fires is ignored (state is still stop).

Test Plan:
- Reset, then wr_ps2 with din=0x55, RTS_CNT=15, device model clocking at period 200 cycles:
  - ps2c low exactly 16 cycles.
  - Device samples on rising edges: 0,1,0,1,0,1,0,1,0, parity 1, stop 1.
  - tx_done_tick is a single pulse on the 11th falling edge; tx_idle returns to 1.
- din=0xF4 (5 ones): parity bit 0 sampled; data LSB-first 0,0,1,0,1,1,1,1.
- Glitch: during data, inject 5-cycle low pulses on ps2c between real edges; no extra shift, and the sampled bit sequence is unchanged.
- wr_ps2 pulsed with din=0xAA while in data: no effect; the transmitted byte remains the original, and one done tick results.
- Assert reset for 1 cycle after the 4th data falling edge:
  - Both lines are Z the next cycle, tx_idle=1, no tx_done_tick.
  - A fresh wr_ps2 with 0x55 then completes correctly.
- Line drive check across a whole frame: ps2c/ps2d are never driven to 1 (only 0 or Z).

Source files
------------

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit the clock, then shift start, 8 data bits
// (LSB first), odd parity and stop onto the shared open-drain lines, clocked by the device.
module ps2_tx #(
    parameter int RTS_CNT  = 8191,
    parameter int FILT_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic [2:0] state_dbg
);

    localparam int CW = (RTS_CNT < 2) ? 1 : $clog2(RTS_CNT + 1);
    localparam logic [CW-1:0] RTS_LOAD = CW'(RTS_CNT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RTS   = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [FILT_LEN-1:0] filter_reg, filter_next;
    logic                f_reg, f_next;
    logic                fall_edge;
    logic [CW-1:0]       c_reg, c_next;
    logic [3:0]          n_reg, n_next;
    logic [8:0]          b_reg, b_next;
    logic                par;
    logic                c_low, d_low;

    // Open-drain drivers: a line is either pulled low or left to the external pull-up.
    assign ps2c = c_low ? 1'b0 : 1'bz;
    assign ps2d = d_low ? 1'b0 : 1'bz;

    assign state_dbg = state_reg;
    assign par       = ~^din;

    // The filtered clock only changes once FILT_LEN consecutive samples agree.
    always_comb begin
        filter_next = {ps2c, filter_reg[FILT_LEN-1:1]};
        if (&filter_next)
            f_next = 1'b1;
        else if (~|filter_next)
            f_next = 1'b0;
        else
            f_next = f_reg;
        fall_edge = f_reg & ~f_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            filter_reg <= '0;
            f_reg      <= 1'b0;
            c_reg      <= '0;
            n_reg      <= '0;
            b_reg      <= '0;
        end else begin
            state_reg  <= state_next;
            filter_reg <= filter_next;
            f_reg      <= f_next;
            c_reg      <= c_next;
            n_reg      <= n_next;
            b_reg      <= b_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        c_next       = c_reg;
        n_next       = n_reg;
        b_next       = b_reg;
        tx_done_tick = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (wr_ps2) begin
                    b_next     = {par, din};
                    c_next     = RTS_LOAD;
                    state_next = S_RTS;
                end
            end
            S_RTS: begin
                if (c_reg == '0)
                    state_next = S_START;
                else
                    c_next = c_reg - 1'b1;
            end
            S_START: begin
                if (fall_edge) begin
                    n_next     = 4'd8;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                // Shifting here means the new bit appears the cycle after the falling edge.
                if (fall_edge) begin
                    b_next = {1'b0, b_reg[8:1]};
                    if (n_reg == 4'd0)
                        state_next = S_STOP;
                    else
                        n_next = n_reg - 1'b1;
                end
            end
            S_STOP: begin
                if (fall_edge) begin
                    tx_done_tick = 1'b1;
                    state_next   = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        c_low   = 1'b0;
        d_low   = 1'b0;
        tx_idle = 1'b0;
        case (state_reg)
            S_IDLE:  tx_idle = 1'b1;
            S_RTS:   c_low   = 1'b1;
            S_START: d_low   = 1'b1;
            S_DATA:  d_low   = ~b_reg[0];
            S_STOP:  ;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 device model clocks frames out of the transmitter and
// compares each sampled bit against a frame built from the byte's value.
module tb_ps2_tx;

  localparam int RTS_CNT  = 15;
  localparam int FILT_LEN = 8;
  localparam int HALF     = 100;

  logic       clk;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] din;
  logic       tx_idle;
  logic       tx_done_tick;
  logic [2:0] state_dbg;
  logic       dev_c_low;
  wire        ps2c;
  wire        ps2d;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c_low ? 1'b0 : 1'bz;

  ps2_tx #(.RTS_CNT(RTS_CNT), .FILT_LEN(FILT_LEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int bad_lvl = 0;
  logic exp_q[$];

  always @(negedge clk) begin
    if (tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;
    if ((ps2c !== 1'b0 && ps2c !== 1'b1) || (ps2d !== 1'b0 && ps2d !== 1'b1))
      bad_lvl <= bad_lvl + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference frame: start 0, data LSB first, odd parity, stop 1
  task automatic push_frame(input logic [7:0] value);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(value[i]);
      if (value[i]) ones++;
    end
    exp_q.push_back((ones % 2) == 0);
    exp_q.push_back(1'b1);
  endtask

  task automatic sample_bit(input string tag);
    logic e;
    check({tag, "_avail"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, 32'(ps2d), 32'(e));
    end
  endtask

  // driver: one-cycle start strobe, then measure the inhibit length
  task automatic send(input logic [7:0] value);
    int cnt;
    @(negedge clk);
    wr_ps2 = 1'b1;
    din    = value;
    @(negedge clk);
    wr_ps2 = 1'b0;
    din    = 8'h00;
    push_frame(value);
    cnt = 0;
    while (ps2c === 1'b0 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("rts_low_cycles", 32'(cnt), 32'(RTS_CNT + 1));
  endtask

  // device model: samples the start bit after the host releases the clock, then
  // generates 11 falling edges; bits are sampled just after each rising edge.
  task automatic device_frame(input bit glitch, input bit inject, input int abort_k);
    int base;
    base = done_cnt;
    repeat (50) @(negedge clk);
    check("tx_idle_busy", 32'(tx_idle), 32'd0);
    sample_bit("start_bit");
    for (int k = 1; k <= 11; k++) begin
      check("no_early_done", 32'(done_cnt - base), 32'd0);
      dev_c_low = 1'b1;
      if (k == abort_k) begin
        repeat (20) @(negedge clk);
        dev_c_low = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ps2c", 32'(ps2c), 32'd1);
        check("abort_ps2d", 32'(ps2d), 32'd1);
        check("abort_idle", 32'(tx_idle), 32'd1);
        check("abort_tick", 32'(tx_done_tick), 32'd0);
        repeat (300) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - base), 32'd0);
        exp_q.delete();
        return;
      end
      repeat (HALF / 2) @(negedge clk);
      check("ps2c_dev_low", 32'(ps2c), 32'd0);
      repeat (HALF / 2) @(negedge clk);
      if (k == 11) begin
        check("done_once", 32'(done_cnt - base), 32'd1);
        check("idle_after", 32'(tx_idle), 32'd1);
        dev_c_low = 1'b0;
        repeat (HALF) @(negedge clk);
        check("done_still_once", 32'(done_cnt - base), 32'd1);
        check("frame_consumed", 32'(exp_q.size()), 32'd0);
        return;
      end
      dev_c_low = 1'b0;
      repeat (2) @(negedge clk);
      sample_bit($sformatf("bit%0d", k));
      if (inject && k == 3) begin
        wr_ps2 = 1'b1;
        din    = 8'hAA;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din    = 8'h00;
        repeat (27) @(negedge clk);
      end else begin
        repeat (28) @(negedge clk);
      end
      if (glitch && k <= 9) begin
        dev_c_low = 1'b1;
        repeat (5) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (HALF - 35) @(negedge clk);
      end else begin
        repeat (HALF - 30) @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [7:0] v;
    reset     = 1'b1;
    wr_ps2    = 1'b0;
    din       = 8'h00;
    dev_c_low = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_idle", 32'(tx_idle), 32'd1);
    check("reset_tick", 32'(tx_done_tick), 32'd0);
    check("reset_ps2c", 32'(ps2c), 32'd1);
    check("reset_ps2d", 32'(ps2d), 32'd1);
    repeat (20) @(negedge clk);

    send(8'h55);
    device_frame(1'b0, 1'b0, 0);

    send(8'hF4);
    device_frame(1'b0, 1'b0, 0);

    v = 8'($urandom_range(0, 255));
    send(v);
    device_frame(1'b1, 1'b0, 0);

    v = 8'($urandom_range(0, 255));
    if (v == 8'hAA) v = 8'h3C;
    send(v);
    device_frame(1'b0, 1'b1, 0);

    send(8'h55);
    device_frame(1'b0, 1'b0, 5);
    repeat (20) @(negedge clk);

    send(8'h55);
    device_frame(1'b0, 1'b0, 0);

    for (int i = 0; i < 2; i++) begin
      v = 8'($urandom);
      send(v);
      device_frame(1'($urandom_range(0, 1)), 1'b0, 0);
    end

    check("line_levels", 32'(bad_lvl), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
